// File: rtl/dma_pkg.sv
// Shared types and constants for the DMA controller slice.
package dma_pkg;

    // Command encoding as driven by mips_pipeline; 2'b11 is reserved and acts as "none".
    typedef enum logic [1:0] {
        DMA_NONE = 2'b00,
        DMA_D2S  = 2'b01,
        DMA_S2D  = 2'b10
    } dma_cmd_t;

    // Transfer sequencer states.
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD_REQ   = 3'd1,
        RD_WAIT  = 3'd2,
        SR_WRITE = 3'd3,
        SR_READ  = 3'd4,
        SR_WAIT  = 3'd5,
        WR_REQ   = 3'd6,
        DONE     = 3'd7
    } dma_state_t;

    // Word counter width; the largest transfer is therefore 1023 words.
    localparam int DMA_CNT_W     = 10;
    localparam int DMA_MAX_WORDS = 1023;

    // Only the two defined directions start a transfer.
    function automatic logic cmd_is_valid(input logic [1:0] cmd);
        return (cmd == DMA_D2S) || (cmd == DMA_S2D);
    endfunction

endpackage

// File: rtl/dma_addr_counter.sv
// Holds the latched source/destination/width of a transfer plus the word index,
// and presents the current SRAM word addresses and DDR byte addresses.
module dma_addr_counter
    import dma_pkg::*;
#(
    parameter int SRAM_AW = 14,
    parameter int DDR_AW  = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load,
    input  logic                 inc,
    input  logic [31:0]          src,
    input  logic [31:0]          dst,
    input  logic [DMA_CNT_W-1:0] width,
    output logic [SRAM_AW-1:0]   sram_src_addr,
    output logic [SRAM_AW-1:0]   sram_dst_addr,
    output logic [DDR_AW-1:0]    ddr_src_addr,
    output logic [DDR_AW-1:0]    ddr_dst_addr,
    output logic                 last
);

    logic [31:2]          src_q;
    logic [31:2]          dst_q;
    logic [DMA_CNT_W-1:0] width_q;
    logic [DMA_CNT_W-1:0] idx;
    logic [31:0]          idx_bytes;
    logic [31:0]          ddr_src_full;
    logic [31:0]          ddr_dst_full;

    // Byte-offset bits of the command addresses carry no information (word aligned).
    logic unused_low_bits;
    assign unused_low_bits = ^{src[1:0], dst[1:0]};

    // Latch the command on acceptance, then step the word index once per moved word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            src_q   <= '0;
            dst_q   <= '0;
            width_q <= '0;
            idx     <= '0;
        end else if (load) begin
            src_q   <= src[31:2];
            dst_q   <= dst[31:2];
            width_q <= width;
            idx     <= '0;
        end else if (inc) begin
            idx <= idx + DMA_CNT_W'(1);
        end
    end

    // DDR addresses wrap modulo 2^32; SRAM word addresses wrap modulo 2^SRAM_AW.
    assign idx_bytes     = {{(30 - DMA_CNT_W){1'b0}}, idx, 2'b00};
    assign ddr_src_full  = {src_q, 2'b00} + idx_bytes;
    assign ddr_dst_full  = {dst_q, 2'b00} + idx_bytes;
    assign ddr_src_addr  = ddr_src_full[DDR_AW-1:0];
    assign ddr_dst_addr  = ddr_dst_full[DDR_AW-1:0];
    assign sram_src_addr = src_q[SRAM_AW+1:2] + SRAM_AW'(idx);
    assign sram_dst_addr = dst_q[SRAM_AW+1:2] + SRAM_AW'(idx);

    // The word currently in flight is the final one of the transfer.
    assign last = ((idx + DMA_CNT_W'(1)) == width_q);

endmodule

// File: rtl/dma_ctrl.sv
// DMA controller fed by mips_pipeline's DMA command outputs. Moves dmaWidth words
// between DDR and SRAM (01 = DDR->SRAM, 10 = SRAM->DDR) while stalling the CPU.
// Optional build macro: DMA_STATS_EN adds dmaCycles, the stall-cycle count of the
// current or most recent transfer.
//
// DDR handshake: a request is offered while ddrReq=1 and is taken on a clock edge
// where ddrReady=1; until then ddrReq, ddrWe, ddrAddr and ddrWd hold their values.
// Read data is taken on the first ddrRvalid=1 seen in RD_WAIT and ignored elsewhere.
module dma_ctrl
    import dma_pkg::*;
#(
    parameter int SRAM_AW = 14,
    parameter int DDR_AW  = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [1:0]         dmaCmd,
    input  logic [31:0]        dmaSrcAddress,
    input  logic [31:0]        dmaDstAddress,
    input  logic [9:0]         dmaWidth,
    output logic               stall,
    output logic [SRAM_AW-1:0] sramAddr,
    output logic               sramWe,
    output logic [31:0]        sramWd,
    input  logic [31:0]        sramRd,
    output logic               ddrReq,
    output logic               ddrWe,
    output logic [DDR_AW-1:0]  ddrAddr,
    output logic [31:0]        ddrWd,
    input  logic               ddrReady,
    input  logic               ddrRvalid,
    input  logic [31:0]        ddrRd,
`ifdef DMA_STATS_EN
    output logic [31:0]        dmaCycles,
`endif
    output logic [2:0]         dbg_state
);

    dma_state_t         state;
    dma_state_t         state_next;
    logic               cmd_ok;
    logic               accept;
    logic               cnt_inc;
    logic               last_word;
    logic [31:0]        data_q;
    logic [SRAM_AW-1:0] sram_src_addr;
    logic [SRAM_AW-1:0] sram_dst_addr;
    logic [DDR_AW-1:0]  ddr_src_addr;
    logic [DDR_AW-1:0]  ddr_dst_addr;

    assign cmd_ok    = cmd_is_valid(dmaCmd);
    assign accept    = (state == IDLE) && cmd_ok;
    // A word is finished when it is written to SRAM or its DDR write is taken.
    assign cnt_inc   = (state == SR_WRITE) || ((state == WR_REQ) && ddrReady);
    assign dbg_state = state;

    dma_addr_counter #(
        .SRAM_AW (SRAM_AW),
        .DDR_AW  (DDR_AW)
    ) u_addr_counter (
        .clk           (clk),
        .reset         (reset),
        .load          (accept),
        .inc           (cnt_inc),
        .src           (dmaSrcAddress),
        .dst           (dmaDstAddress),
        .width         (dmaWidth),
        .sram_src_addr (sram_src_addr),
        .sram_dst_addr (sram_dst_addr),
        .ddr_src_addr  (ddr_src_addr),
        .ddr_dst_addr  (ddr_dst_addr),
        .last          (last_word)
    );

    // State register; reset abandons any transfer in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next-state sequencing of both transfer loops.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (cmd_ok) begin
                    if (dmaWidth == '0)         state_next = DONE;
                    else if (dmaCmd == DMA_D2S) state_next = RD_REQ;
                    else                        state_next = SR_READ;
                end
            end
            RD_REQ:   if (ddrReady)  state_next = RD_WAIT;
            RD_WAIT:  if (ddrRvalid) state_next = SR_WRITE;
            SR_WRITE: state_next = last_word ? DONE : RD_REQ;
            SR_READ:  state_next = SR_WAIT;
            SR_WAIT:  state_next = WR_REQ;
            WR_REQ:   if (ddrReady) state_next = last_word ? DONE : SR_READ;
            DONE:     state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    // One-word buffer between the read side and the write side of each loop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q <= '0;
        end else if ((state == RD_WAIT) && ddrRvalid) begin
            data_q <= ddrRd;
        end else if (state == SR_WAIT) begin
            data_q <= sramRd;
        end
    end

    // Outputs decoded from state; stall also covers the command cycle in IDLE.
    always_comb begin
        stall    = 1'b0;
        sramAddr = '0;
        sramWe   = 1'b0;
        sramWd   = '0;
        ddrReq   = 1'b0;
        ddrWe    = 1'b0;
        ddrAddr  = '0;
        ddrWd    = '0;
        unique case (state)
            IDLE: stall = cmd_ok && !reset;
            DONE: stall = 1'b0;
            default: stall = !reset;
        endcase
        unique case (state)
            RD_REQ: begin
                ddrReq  = 1'b1;
                ddrAddr = ddr_src_addr;
            end
            SR_WRITE: begin
                sramWe   = 1'b1;
                sramAddr = sram_dst_addr;
                sramWd   = data_q;
            end
            SR_READ: begin
                sramAddr = sram_src_addr;
            end
            WR_REQ: begin
                ddrReq  = 1'b1;
                ddrWe   = 1'b1;
                ddrAddr = ddr_dst_addr;
                ddrWd   = data_q;
            end
            default: begin
            end
        endcase
    end

`ifdef DMA_STATS_EN
    // Stall-cycle count: restarts at 1 on the accepting cycle, frozen once DONE is reached.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)       dmaCycles <= '0;
        else if (accept) dmaCycles <= 32'd1;
        else if (stall)  dmaCycles <= dmaCycles + 32'd1;
    end
`endif

endmodule
